astro_rom_arbiter: RTL and testbench

- Shares the two registered read ports of the 550-entry, 4-bit palette-index sprite ROM between NUM_REQ independent pixel requesters (ship, asteroid and projectile draw engines).
- Each cycle grants up to two requests round-robin, drives the ROM addresses, tracks the 1-cycle ROM latency and routes returned data to the owning requester.
- Sits between the per-object sprite address generators and the sprite ROM in the draw pipeline.

---
 rtl/astro_rom_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_astro_rom_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/astro_rom_arbiter.sv
// astro_rom_arbiter
// Shares the two registered read ports of the sprite ROM between NUM_REQ
// pixel requesters. Up to two requests are granted per cycle in round-robin
// order. The ROM addresses are registered, the one-cycle ROM latency is
// tracked with per-port tags, and the returned palette indices are routed
// back to the requester that owns them. A request accepted in cycle t
// produces its rsp_valid pulse in cycle t+3.
//
// Optional build macro: ASTRO_ARB_PRIORITY_EN
//   defined   : requester 0 takes port 1 whenever it requests; port 2 is
//               round-robin over requesters 1..NUM_REQ-1.
//   undefined : pure round-robin over all requesters.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous, active-high reset
//   grant_en_i   0 blocks new grants; responses already in flight complete
//   req_valid_i  per-requester read request
//   req_addr_i   per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//   req_ready_o  combinational grant (accept = valid & ready at rising edge)
//   rsp_valid_o  one-cycle pulse, read data for requester i is valid
//   rsp_data_o   per-requester read data, held between pulses
//   rsp_oor_o    qualifies rsp_valid_o, 1 = address was out of range
//   rom_addr1_o  registered ROM port 1 address
//   rom_addr2_o  registered ROM port 2 address
//   rom_data1_i  ROM port 1 data, valid one cycle after the address
//   rom_data2_i  ROM port 2 data, valid one cycle after the address
module astro_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 550
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      grant_en_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data_o,
    output logic [NUM_REQ-1:0]        rsp_oor_o,
    output logic [ADDR_W-1:0]         rom_addr1_o,
    output logic [ADDR_W-1:0]         rom_addr2_o,
    input  logic [DATA_W-1:0]         rom_data1_i,
    input  logic [DATA_W-1:0]         rom_data2_i
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          scan_id;
    logic                      g1_vld, g2_vld;
    logic [PTR_W-1:0]          g1_id, g2_id;
    logic [ADDR_W-1:0]         g1_addr, g2_addr;
    logic                      g1_oor, g2_oor;

    // stage 1: address registered, ROM reading; stage 2: ROM data valid
    logic [ADDR_W-1:0]         rom_addr1_q, rom_addr2_q;
    logic                      s1_vld1_q, s1_vld2_q, s2_vld1_q, s2_vld2_q;
    logic [PTR_W-1:0]          s1_id1_q, s1_id2_q, s2_id1_q, s2_id2_q;
    logic                      s1_oor1_q, s1_oor2_q, s2_oor1_q, s2_oor2_q;

    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]        rsp_oor_q, rsp_oor_d;
    logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Arbitration: the first hit of the scan goes to port 1, the second to
    // port 2, so port 1 always carries the earlier scan index.
    always_comb begin
        g1_vld   = 1'b0;
        g2_vld   = 1'b0;
        g1_id    = '0;
        g2_id    = '0;
        scan_id  = '0;
        rr_ptr_d = rr_ptr_q;
`ifdef ASTRO_ARB_PRIORITY_EN
        if (grant_en_i && req_valid_i[0]) begin
            g1_vld = 1'b1;
            g1_id  = '0;
        end
        // rr_ptr is an offset into requesters 1..NUM_REQ-1
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            scan_id = PTR_W'(1 + ((int'(rr_ptr_q) + k) % (NUM_REQ - 1)));
            if (grant_en_i && req_valid_i[scan_id]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_id  = scan_id;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_id  = scan_id;
                end
            end
        end
        // next offset after index L is L mod (NUM_REQ-1); requester 0 never moves it
        if (g2_vld) begin
            rr_ptr_d = PTR_W'(int'(g2_id) % (NUM_REQ - 1));
        end else if (g1_vld && (g1_id != '0)) begin
            rr_ptr_d = PTR_W'(int'(g1_id) % (NUM_REQ - 1));
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (grant_en_i && req_valid_i[scan_id]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_id  = scan_id;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_id  = scan_id;
                end
            end
        end
        if (g2_vld) begin
            rr_ptr_d = PTR_W'((int'(g2_id) + 1) % NUM_REQ);
        end else if (g1_vld) begin
            rr_ptr_d = PTR_W'((int'(g1_id) + 1) % NUM_REQ);
        end
`endif
    end

    always_comb begin
        req_ready_o = '0;
        if (g1_vld) req_ready_o[g1_id] = 1'b1;
        if (g2_vld) req_ready_o[g2_id] = 1'b1;
    end

    assign g1_addr = req_addr_i[int'(g1_id)*ADDR_W +: ADDR_W];
    assign g2_addr = req_addr_i[int'(g2_id)*ADDR_W +: ADDR_W];
    assign g1_oor  = (g1_addr >= ADDR_W'(DEPTH));
    assign g2_oor  = (g2_addr >= ADDR_W'(DEPTH));

    // Response routing: the two ports never carry the same id in one cycle,
    // so the two slot writes below cannot collide.
    always_comb begin
        rsp_valid_d = '0;
        rsp_oor_d   = rsp_oor_q;
        rsp_data_d  = rsp_data_q;
        if (s2_vld1_q) begin
            rsp_valid_d[s2_id1_q] = 1'b1;
            rsp_oor_d[s2_id1_q]   = s2_oor1_q;
            rsp_data_d[int'(s2_id1_q)*DATA_W +: DATA_W] = s2_oor1_q ? '0 : rom_data1_i;
        end
        if (s2_vld2_q) begin
            rsp_valid_d[s2_id2_q] = 1'b1;
            rsp_oor_d[s2_id2_q]   = s2_oor2_q;
            rsp_data_d[int'(s2_id2_q)*DATA_W +: DATA_W] = s2_oor2_q ? '0 : rom_data2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            rom_addr1_q <= '0;
            rom_addr2_q <= '0;
            s1_vld1_q   <= 1'b0;
            s1_vld2_q   <= 1'b0;
            s1_id1_q    <= '0;
            s1_id2_q    <= '0;
            s1_oor1_q   <= 1'b0;
            s1_oor2_q   <= 1'b0;
            s2_vld1_q   <= 1'b0;
            s2_vld2_q   <= 1'b0;
            s2_id1_q    <= '0;
            s2_id2_q    <= '0;
            s2_oor1_q   <= 1'b0;
            s2_oor2_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_oor_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            // idle or out-of-range ports read address 0
            rom_addr1_q <= (g1_vld && !g1_oor) ? g1_addr : '0;
            rom_addr2_q <= (g2_vld && !g2_oor) ? g2_addr : '0;
            s1_vld1_q   <= g1_vld;
            s1_vld2_q   <= g2_vld;
            s1_id1_q    <= g1_id;
            s1_id2_q    <= g2_id;
            s1_oor1_q   <= g1_vld & g1_oor;
            s1_oor2_q   <= g2_vld & g2_oor;
            s2_vld1_q   <= s1_vld1_q;
            s2_vld2_q   <= s1_vld2_q;
            s2_id1_q    <= s1_id1_q;
            s2_id2_q    <= s1_id2_q;
            s2_oor1_q   <= s1_oor1_q;
            s2_oor2_q   <= s1_oor2_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_oor_q   <= rsp_oor_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rom_addr1_o = rom_addr1_q;
    assign rom_addr2_o = rom_addr2_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_oor_o   = rsp_oor_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_astro_rom_arbiter.sv
// Directed bench for astro_rom_arbiter with a per-requester response
// scoreboard and a registered sprite ROM model.
module tb_astro_rom_arbiter;

    localparam int NR = 4;
    localparam int AW = 19;
    localparam int DW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              grant_en;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR*DW-1:0]  rsp_data;
    logic [NR-1:0]     rsp_oor;
    logic [AW-1:0]     rom_addr1, rom_addr2;
    logic [DW-1:0]     rom_data1, rom_data2;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int         due;
        logic [3:0] data;
        logic       oor;
    } exp_t;

    exp_t exp_q [NR][$];

    logic [3:0] cont_mask [4];
    logic [3:0] z_mask;

    astro_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(550)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .grant_en_i  (grant_en),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_oor_o   (rsp_oor),
        .rom_addr1_o (rom_addr1),
        .rom_addr2_o (rom_addr2),
        .rom_data1_i (rom_data1),
        .rom_data2_i (rom_data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rom_val(input logic [AW-1:0] a);
        logic [31:0] v;
        v = 32'(a) * 7 + 3;
        return v[3:0];
    endfunction

    // registered ROM: data appears one cycle after the address
    always @(posedge clk) begin
        rom_data1 <= rom_val(rom_addr1);
        rom_data2 <= rom_val(rom_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // response monitor: pops the expected entry due this cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                logic ev;
                ev = (exp_q[i].size() > 0) && (exp_q[i][0].due == cyc);
                if (ev || rsp_valid[i] === 1'b1) begin
                    chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(rsp_valid[i]), 32'(ev));
                end
                if (ev) begin
                    chk($sformatf("rsp_data[%0d]", i), 32'(rsp_data[i*DW +: DW]), 32'(exp_q[i][0].data));
                    chk($sformatf("rsp_oor[%0d]", i), 32'(rsp_oor[i]), 32'(exp_q[i][0].oor));
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic drive(input logic ge, input logic [3:0] v,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                         input logic [3:0] exp_rdy, input string tag, input bit push);
        logic [AW-1:0] a [NR];
        exp_t e;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        grant_en  = ge;
        req_valid = v;
        req_addr  = {a3, a2, a1, a0};
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (push) begin
            for (int i = 0; i < NR; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    e.due  = cyc + 3;
                    e.oor  = (a[i] >= 550);
                    e.data = e.oor ? 4'h0 : rom_val(a[i]);
                    exp_q[i].push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 4'b0000, '0, '0, '0, '0, 4'b0000, "idle", 1'b1);
    endtask

    initial begin
`ifdef ASTRO_ARB_PRIORITY_EN
        cont_mask[0] = 4'b0011; cont_mask[1] = 4'b0101;
        cont_mask[2] = 4'b1001; cont_mask[3] = 4'b0011;
        z_mask = 4'b0011;
`else
        cont_mask[0] = 4'b0011; cont_mask[1] = 4'b1100;
        cont_mask[2] = 4'b0011; cont_mask[3] = 4'b1100;
        z_mask = 4'b0110;
`endif
        rst       = 1'b1;
        grant_en  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset.rom_addr1", 32'(rom_addr1), 32'h0);
        chk("reset.rom_addr2", 32'(rom_addr2), 32'h0);
        chk("reset.rsp_data", 32'(rsp_data), 32'h0);
        chk("reset.rsp_oor", 32'(rsp_oor), 32'h0);
        rst = 1'b0;

        // single read from requester 0, address 17 holds 4'hA
        drive(1'b1, 4'b0001, 19'd17, '0, '0, '0, 4'b0001, "single", 1'b1);
        chk("single.rom_addr1", 32'(rom_addr1), 32'd17);
        chk("single.rom_addr2", 32'(rom_addr2), 32'd0);
        idle(4);
        chk("single.slot0", 32'(rsp_data[0*DW +: DW]), 32'hA);

        // out of range then last valid entry, requester 2
        drive(1'b1, 4'b0100, '0, '0, 19'd550, '0, 4'b0100, "oor550", 1'b1);
        chk("oor550.rom_addr1", 32'(rom_addr1), 32'd0);
        drive(1'b1, 4'b0100, '0, '0, 19'd549, '0, 4'b0100, "oor549", 1'b1);
        chk("oor549.rom_addr1", 32'(rom_addr1), 32'd549);
        idle(4);
        chk("hold.slot0", 32'(rsp_data[0*DW +: DW]), 32'hA);

        // grant_en gating: pointer must not move during the blocked cycle
        drive(1'b1, 4'b1111, 19'd50, 19'd51, 19'd52, 19'd53, 4'b1001, "gen_pre", 1'b1);
        drive(1'b0, 4'b1111, 19'd60, 19'd61, 19'd62, 19'd63, 4'b0000, "gen_off", 1'b1);
        drive(1'b1, 4'b1111, 19'd70, 19'd71, 19'd72, 19'd73, z_mask, "gen_on", 1'b1);
        idle(4);

        // requesters 0 and 3 streaming
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b1001, 19'(300 + k), '0, '0, 19'(400 + k), 4'b1001, "r0r3", 1'b1);
`ifdef ASTRO_ARB_PRIORITY_EN
            chk("r0r3.rom_addr1", 32'(rom_addr1), 32'(300 + k));
            chk("r0r3.rom_addr2", 32'(rom_addr2), 32'(400 + k));
`else
            chk("r0r3.rom_addr1", 32'(rom_addr1), 32'(400 + k));
            chk("r0r3.rom_addr2", 32'(rom_addr2), 32'(300 + k));
`endif
        end
        idle(4);

        // reset with three reads in flight: none of them may respond
        drive(1'b1, 4'b1110, '0, 19'd5, 19'd6, 19'd7, 4'b0110, "rst_a", 1'b0);
        drive(1'b1, 4'b1000, '0, '0, '0, 19'd7, 4'b1000, "rst_b", 1'b0);
        chk("rst.rom_addr1_pre", 32'(rom_addr1), 32'd7);
        rst = 1'b1;
        #1;
        chk("rst.rom_addr1_async", 32'(rom_addr1), 32'd0);
        chk("rst.rom_addr2_async", 32'(rom_addr2), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0000, '0, '0, '0, '0, 4'b0000, "rst_idle", 1'b1);
            chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
        end

        // full contention starting from rr_ptr = 0
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b1111, 19'(10 + k), 19'(20 + k), 19'(30 + k), 19'(40 + k),
                  cont_mask[k], "contend", 1'b1);
        end
        idle(5);

        for (int i = 0; i < NR; i++) begin
            chk($sformatf("outstanding[%0d]", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
